// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares one data memory between the CPU load/store path (port 0) and a
// host/debug/loader port (port 1). Port 0 has fixed priority. A starvation
// counter forces a port 1 grant after STARVE_LIM consecutive waiting cycles.
// Port 1 may lock the memory across a multi-word sequence.
//
// Ports
//   i_clk                    clock, all state on rising edge
//   i_rst_n                  asynchronous active-low reset
//   i_req0/1                 access request, held stable until granted
//   i_we0/1                  1 = write, 0 = read
//   i_addr0/1, i_wdata0/1    per-port byte address / write data
//   i_lock1                  port 1 keeps ownership after its current grant
//   o_gnt0/1                 combinational grant, transfer at the next edge
//   o_rvalid0/1              one-cycle pulse, read data valid
//   o_rdata0/1               registered read data, held until the next read
//   o_cpu_stall              port 0 requesting but not granted
//   o_mem_en, o_mem_we       memory access / write enable
//   o_mem_addr, o_mem_wdata  muxed address / write data (0 when idle)
//   i_mem_rdata              combinational read data from the memory
//
// State table
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_ARB   | normal arbitration: starved port 1, else port 0, else port 1
//   ST_LOCK1 | port 1 owns the memory; port 0 is held off
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic              i_lock1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_cpu_stall,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int              CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM  = CNT_W'(STARVE_LIM);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_LOCK1 = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               w_starved;
    logic               w_arb_gnt0;
    logic               w_arb_gnt1;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               r_rvalid0;
    logic               r_rvalid1;
    logic [DATA_W-1:0]  r_rdata0;
    logic [DATA_W-1:0]  r_rdata1;
    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0]  w_mem_wdata;

    assign w_starved = (r_wait_cnt == LIM);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Grant decision and next state
    // ------------------------------------------------------------------
    always_comb begin
        w_arb_gnt0  = 1'b0;
        w_arb_gnt1  = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB: begin
                if (w_starved && i_req1) begin
                    w_arb_gnt1 = 1'b1;
                end else if (i_req0) begin
                    w_arb_gnt0 = 1'b1;
                end else if (i_req1) begin
                    w_arb_gnt1 = 1'b1;
                end
                if (w_arb_gnt1 && i_lock1) begin
                    w_state_nxt = ST_LOCK1;
                end
            end
            ST_LOCK1: begin
                w_arb_gnt1 = i_req1;
                // Dropping lock1 releases ownership whether or not a final
                // transfer happens this cycle; that transfer still completes.
                if (!i_lock1) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // Grants are forced off while reset is held so the memory sees no
    // access even though the request inputs may be active.
    assign w_gnt0 = w_arb_gnt0 & i_rst_n;
    assign w_gnt1 = w_arb_gnt1 & i_rst_n;

    // ------------------------------------------------------------------
    // Port 1 starvation counter (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (!i_req1 || w_gnt1) begin
            r_wait_cnt <= '0;
        end else if (!w_starved) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Memory-side mux
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt0) begin
            w_mem_we    = i_we0;
            w_mem_addr  = i_addr0;
            w_mem_wdata = i_wdata0;
        end else if (w_gnt1) begin
            w_mem_we    = i_we1;
            w_mem_addr  = i_addr1;
            w_mem_wdata = i_wdata1;
        end
    end

    // ------------------------------------------------------------------
    // Read return: capture at the grant edge, pulse rvalid the next cycle
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~i_we0;
            r_rvalid1 <= w_gnt1 & ~i_we1;
            if (w_gnt0 && !i_we0) begin
                r_rdata0 <= i_mem_rdata;
            end
            if (w_gnt1 && !i_we1) begin
                r_rdata1 <= i_mem_rdata;
            end
        end
    end

    assign o_gnt0      = w_gnt0;
    assign o_gnt1      = w_gnt1;
    assign o_cpu_stall = i_req0 & ~w_gnt0;
    assign o_mem_en    = w_gnt0 | w_gnt1;
    assign o_mem_we    = w_mem_we;
    assign o_mem_addr  = w_mem_addr;
    assign o_mem_wdata = w_mem_wdata;
    assign o_rvalid0   = r_rvalid0;
    assign o_rvalid1   = r_rvalid1;
    assign o_rdata0    = r_rdata0;
    assign o_rdata1    = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter (STARVE_LIM = 4). Inputs change 1 ns after
// a rising edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, cpu_stall, mem_en, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_LIM(4)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req0     (req0),
        .i_req1     (req1),
        .i_we0      (we0),
        .i_we1      (we1),
        .i_addr0    (addr0),
        .i_addr1    (addr1),
        .i_wdata0   (wdata0),
        .i_wdata1   (wdata1),
        .i_lock1    (lock1),
        .o_gnt0     (gnt0),
        .o_gnt1     (gnt1),
        .o_rvalid0  (rvalid0),
        .o_rvalid1  (rvalid1),
        .o_rdata0   (rdata0),
        .o_rdata1   (rdata1),
        .o_cpu_stall(cpu_stall),
        .o_mem_en   (mem_en),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req0      = 1'b1;
        req1      = 1'b1;
        we0       = 1'b0;
        we1       = 1'b0;
        lock1     = 1'b0;
        addr0     = 32'h10;
        addr1     = 32'h30;
        wdata0    = 32'h0;
        wdata1    = 32'h0;
        mem_rdata = 32'h1111_1111;

        // ---------------- reset with both ports requesting ----------------
        settle();
        chk1 ("rst_gnt0",    gnt0,    1'b0);
        chk1 ("rst_gnt1",    gnt1,    1'b0);
        chk1 ("rst_mem_en",  mem_en,  1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1 ("rst_rvalid0", rvalid0, 1'b0);
        chk1 ("rst_rvalid1", rvalid1, 1'b0);
        chk32("rst_rdata0",  rdata0,  32'h0);
        chk1 ("rst_stall",   cpu_stall, 1'b1);

        next_cyc();
        rst_n = 1'b1;
        settle();
        chk1 ("rel_gnt0",    gnt0,    1'b1);
        chk1 ("rel_gnt1",    gnt1,    1'b0);
        chk1 ("rel_stall",   cpu_stall, 1'b0);
        chk32("rel_mem_addr", mem_addr, 32'h10);

        next_cyc();
        req0 = 1'b0;
        req1 = 1'b0;
        settle();
        chk1 ("rel_rvalid0", rvalid0, 1'b1);
        chk32("rel_rdata0",  rdata0,  32'h1111_1111);
        chk1 ("idle_mem_en", mem_en,  1'b0);

        // ---------------- CPU read alone ----------------
        next_cyc();
        req0      = 1'b1;
        addr0     = 32'h10;
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk1 ("rd0_gnt0",  gnt0,      1'b1);
        chk1 ("rd0_stall", cpu_stall, 1'b0);
        chk1 ("rd0_mem_we", mem_we,   1'b0);

        next_cyc();
        req0      = 1'b0;
        mem_rdata = 32'h0;
        settle();
        chk1 ("rd0_rvalid0", rvalid0, 1'b1);
        chk32("rd0_rdata0",  rdata0,  32'hDEAD_BEEF);
        chk1 ("rd0_rvalid1", rvalid1, 1'b0);

        next_cyc();
        settle();
        chk1 ("rd0_pulse_end", rvalid0, 1'b0);
        chk32("rd0_rdata_hold", rdata0, 32'hDEAD_BEEF);

        // ---------------- contention / starvation ----------------
        // Port 1 waits 4 cycles, wins cycle 5, and the counter restarts so
        // it wins again in cycle 10.
        next_cyc();
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 32'h20;
        addr1 = 32'h30;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) next_cyc();
            mem_rdata = 32'hC0DE_0000 + i;
            settle();
            chk1("starve_gnt1",  gnt1,      (i == 5) || (i == 10));
            chk1("starve_gnt0",  gnt0,      !((i == 5) || (i == 10)));
            chk1("starve_stall", cpu_stall, (i == 5) || (i == 10));
            if (i == 5) chk32("starve_addr1", mem_addr, 32'h30);
            if (i == 6) begin
                chk1 ("starve_rvalid1", rvalid1, 1'b1);
                chk32("starve_rdata1",  rdata1,  32'hC0DE_0005);
                chk1 ("starve_rvalid0", rvalid0, 1'b0);
            end
        end

        next_cyc();
        req0 = 1'b0;
        req1 = 1'b0;
        settle();

        // ---------------- locked write burst ----------------
        next_cyc();
        req0   = 1'b1;
        addr0  = 32'h40;
        req1   = 1'b1;
        we1    = 1'b1;
        addr1  = 32'h100;
        wdata1 = 32'hAAAA_0100;
        lock1  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) next_cyc();
            settle();
            chk1("lk_pre_gnt1", gnt1, i == 5);
        end
        chk1 ("lk_w0_we",    mem_we,    1'b1);
        chk32("lk_w0_wdata", mem_wdata, 32'hAAAA_0100);

        next_cyc();
        addr1  = 32'h104;
        wdata1 = 32'hAAAA_0104;
        settle();
        chk1 ("lk_w1_gnt1",  gnt1,      1'b1);
        chk1 ("lk_w1_gnt0",  gnt0,      1'b0);
        chk1 ("lk_w1_stall", cpu_stall, 1'b1);
        chk32("lk_w1_addr",  mem_addr,  32'h104);
        chk1 ("lk_w1_rvalid1", rvalid1, 1'b0);

        next_cyc();
        addr1  = 32'h108;
        wdata1 = 32'hAAAA_0108;
        lock1  = 1'b0;
        settle();
        chk1 ("lk_w2_gnt1",  gnt1,      1'b1);
        chk1 ("lk_w2_gnt0",  gnt0,      1'b0);
        chk32("lk_w2_wdata", mem_wdata, 32'hAAAA_0108);

        next_cyc();
        req1 = 1'b0;
        we1  = 1'b0;
        settle();
        chk1("lk_after_gnt0",  gnt0,      1'b1);
        chk1("lk_after_stall", cpu_stall, 1'b0);

        // ---------------- lock held while port 1 idles ----------------
        next_cyc();
        req0      = 1'b0;
        req1      = 1'b1;
        addr1     = 32'h200;
        lock1     = 1'b1;
        mem_rdata = 32'h5EED_0200;
        settle();
        chk1("li_gnt1", gnt1, 1'b1);

        next_cyc();
        req0      = 1'b1;
        req1      = 1'b0;
        mem_rdata = 32'h0;
        settle();
        chk1 ("li_rvalid1", rvalid1,   1'b1);
        chk32("li_rdata1",  rdata1,    32'h5EED_0200);
        chk1 ("li_c1_gnt0", gnt0,      1'b0);
        chk1 ("li_c1_stall", cpu_stall, 1'b1);
        chk1 ("li_c1_mem_en", mem_en,  1'b0);

        for (int i = 2; i <= 3; i++) begin
            next_cyc();
            settle();
            chk1("li_hold_gnt0", gnt0, 1'b0);
        end

        next_cyc();
        lock1 = 1'b0;
        settle();
        chk1("li_drop_gnt0", gnt0, 1'b0);

        // lock1 without a port 1 grant must not re-enter the locked state
        next_cyc();
        lock1 = 1'b1;
        settle();
        chk1("li_free_gnt0", gnt0, 1'b1);

        next_cyc();
        lock1 = 1'b0;
        settle();
        chk1("nolock_gnt0", gnt0, 1'b1);

        // ---------------- reset during a port 1 read ----------------
        next_cyc();
        req0      = 1'b0;
        req1      = 1'b1;
        we1       = 1'b0;
        addr1     = 32'h300;
        mem_rdata = 32'hBAD0_BAD0;
        settle();
        chk1("mr_gnt1", gnt1, 1'b1);

        #1;
        rst_n = 1'b0;
        req0  = 1'b1;
        #1;
        chk1 ("mr_async_gnt1",   gnt1,    1'b0);
        chk1 ("mr_async_mem_en", mem_en,  1'b0);
        chk32("mr_async_rdata1", rdata1,  32'h0);
        chk32("mr_async_rdata0", rdata0,  32'h0);

        next_cyc();
        settle();
        chk1 ("mr_rvalid1", rvalid1, 1'b0);
        chk32("mr_rdata1",  rdata1,  32'h0);

        // Release with both ports requesting: counter must restart at 0.
        next_cyc();
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) next_cyc();
            settle();
            if (i == 1) chk1("mr_rel_rvalid1", rvalid1, 1'b0);
            chk1("mr_rel_gnt1", gnt1, i == 5);
        end

        next_cyc();
        req0 = 1'b0;
        req1 = 1'b0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
